bus_rr_sched: RTL

- Round-robin scheduler/controller that shares a single broadcast-data bus between `drvrs` device FIFOs.
- Polls each device's pending flag and pops one packet from the granted device.
- Decodes the destination ID in the packet's top 8 bits and pushes the packet to the destination device(s), honouring per-destination full backpressure.
- Sits between the device-side FIFO interfaces and the bus fabric; one packet in flight at a time.

---
 rtl/bus_rr_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bus_rr_sched.sv
// Round-robin scheduler sharing one broadcast-data bus between device FIFOs.
// Pops one packet from the granted device and delivers it to the destination(s) encoded in its top byte.
//
// state  | meaning
// IDLE   | pick next pending device after last_grant
// POP    | dequeue head of granted device, latch packet
// DECODE | resolve targets; drop invalid destinations
// WAIT   | hold until no target is full, or time out
// PUSH   | write packet to all targets in one cycle
module bus_rr_sched #(
   parameter int         drvrs     = 4,
   parameter int         pckg_sz   = 16,
   parameter logic [7:0] broadcast = 8'hFF,
   parameter int         timeout   = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [drvrs-1:0]           pndng,
   input  logic [drvrs*pckg_sz-1:0]   D_pop,
   input  logic [drvrs-1:0]           full,
   output logic [drvrs-1:0]           pop,
   output logic [drvrs-1:0]           push,
   output logic [pckg_sz-1:0]         D_push,
   output logic [3:0]                 grant_id,
   output logic                       busy,
   output logic [15:0]                drop_cnt
);

   localparam int               WCW = $clog2(timeout + 1);
   localparam logic [drvrs-1:0] ONE = drvrs'(1);

   typedef enum logic [2:0] {IDLE, POP, DECODE, WAIT, PUSH} state_t;

   state_t               state, state_nxt;
   logic [3:0]           grant_q, grant_nxt;
   logic [3:0]           last_q, last_nxt;
   logic [pckg_sz-1:0]   pkt_q, pkt_nxt;
   logic [drvrs-1:0]     tgt_q, tgt_nxt;
   logic [WCW-1:0]       wait_q, wait_nxt;
   logic [15:0]          drop_q, drop_nxt;
   logic [pckg_sz-1:0]   dpush_q, dpush_nxt;

   logic [7:0]           dest;
   logic [drvrs-1:0]     gnt_1h;
   logic [drvrs-1:0]     dec_tgt;
   logic [pckg_sz-1:0]   pkt_sel;
   logic [15:0]          drop_inc;
   logic                 found;
   int                   k;

   assign dest     = pkt_q[pckg_sz-1 -: 8];
   assign gnt_1h   = ONE << grant_q;
   assign drop_inc = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

   always_comb begin
      pkt_sel = '0;
      for (int i = 0; i < drvrs; i++)
         if (grant_q == 4'(i)) pkt_sel = D_pop[i*pckg_sz +: pckg_sz];
   end

   // Zero targets means the destination is unusable and the packet is dropped.
   always_comb begin
      dec_tgt = '0;
      if (dest == broadcast)
         dec_tgt = ~gnt_1h;
      else if (int'(dest) < drvrs && dest[3:0] != grant_q)
         dec_tgt = ONE << dest;
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_q;
      last_nxt  = last_q;
      pkt_nxt   = pkt_q;
      tgt_nxt   = tgt_q;
      wait_nxt  = wait_q;
      drop_nxt  = drop_q;
      dpush_nxt = dpush_q;
      pop       = '0;
      push      = '0;
      found     = 1'b0;
      k         = 0;
      case (state)
         IDLE: begin
            for (int i = 1; i <= drvrs; i++) begin
               k = int'(last_q) + i;
               if (k >= drvrs) k = k - drvrs;
               for (int j = 0; j < drvrs; j++)
                  if (!found && j == k && pndng[j]) begin
                     found     = 1'b1;
                     grant_nxt = 4'(j);
                  end
            end
            if (found) state_nxt = POP;
         end
         POP: begin
            pop       = gnt_1h;
            pkt_nxt   = pkt_sel;
            state_nxt = DECODE;
         end
         DECODE: begin
            if (dec_tgt == '0) begin
               drop_nxt  = drop_inc;
               last_nxt  = grant_q;
               state_nxt = IDLE;
            end else begin
               tgt_nxt  = dec_tgt;
               wait_nxt = '0;
               // Unblocked targets skip WAIT to keep the 4-cycle packet slot.
               if ((dec_tgt & full) == '0) begin
                  dpush_nxt = pkt_q;
                  state_nxt = PUSH;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if ((tgt_q & full) == '0) begin
               dpush_nxt = pkt_q;
               state_nxt = PUSH;
            end else if (wait_q == WCW'(timeout - 1)) begin
               drop_nxt  = drop_inc;
               last_nxt  = grant_q;
               state_nxt = IDLE;
            end else begin
               wait_nxt = wait_q + 1'b1;
            end
         end
         PUSH: begin
            push      = tgt_q;
            last_nxt  = grant_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         grant_q <= '0;
         last_q  <= 4'(drvrs - 1);
         pkt_q   <= '0;
         tgt_q   <= '0;
         wait_q  <= '0;
         drop_q  <= '0;
         dpush_q <= '0;
      end else begin
         state   <= state_nxt;
         grant_q <= grant_nxt;
         last_q  <= last_nxt;
         pkt_q   <= pkt_nxt;
         tgt_q   <= tgt_nxt;
         wait_q  <= wait_nxt;
         drop_q  <= drop_nxt;
         dpush_q <= dpush_nxt;
      end
   end

   assign grant_id = grant_q;
   assign busy     = (state != IDLE);
   assign drop_cnt = drop_q;
   assign D_push   = dpush_q;

endmodule
